// File: rtl/dmem_arbiter_pkg.sv
// Shared data-memory types: bus command/size encodings, FU memory packet,
// and the arbiter's state and port enums.
package sys_defs;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    BYTE   = 2'h0,
    HALF   = 2'h1,
    WORD   = 2'h2,
    DOUBLE = 2'h3
  } MEM_SIZE;

  typedef struct packed {
    BUS_COMMAND      command;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    MEM_SIZE         size;
  } FU_MEM_PACKET;

  typedef enum logic [1:0] {
    IDLE    = 2'h0,
    ISSUE   = 2'h1,
    WAIT_LD = 2'h2,
    ACK     = 2'h3
  } ARB_STATE;

  typedef enum logic {
    PORT_LD = 1'b0,
    PORT_ST = 1'b1
  } ARB_PORT;

endpackage

// File: rtl/dmem_arbiter_lane_align.sv
// Byte-lane alignment between the XLEN core datapath and the 64-bit memory bus.
module mem_lane_align
  import sys_defs::*;
(
  input  logic [2:0]      addr_off,
  input  MEM_SIZE         st_size,
  input  logic [XLEN-1:0] st_data,
  input  logic [63:0]     rd_data,
  output logic [63:0]     st_lane,
  output logic [XLEN-1:0] ld_aligned
);

  logic [5:0]  shamt;
  logic [63:0] st_mask;
  logic [63:0] rd_shifted;

  always_comb begin
    shamt = {addr_off, 3'b000};
    case (st_size)
      BYTE:    st_mask = 64'h0000_0000_0000_00FF;
      HALF:    st_mask = 64'h0000_0000_0000_FFFF;
      WORD:    st_mask = 64'h0000_0000_FFFF_FFFF;
      default: st_mask = '1;
    endcase
    // Masking to size keeps unused lanes zero even if the FU leaves junk above the operand.
    st_lane    = (64'(st_data) & st_mask) << shamt;
    rd_shifted = rd_data >> shamt;
    ld_aligned = rd_shifted[XLEN-1:0];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory bus between the load and store
// FUs; one transaction outstanding, loads tracked by their bus tag.
module dmem_arbiter
  import sys_defs::*;
#(
  parameter int TAG_BITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ld_req,
  input  FU_MEM_PACKET        ld_mem_packet,
  output logic                ld_ack,
  output logic [XLEN-1:0]     ld_data,
  input  logic                st_req,
  input  FU_MEM_PACKET        st_mem_packet,
  output logic                st_ack,
  input  logic                squash,
  output BUS_COMMAND          proc2Dmem_command,
  output logic [XLEN-1:0]     proc2Dmem_addr,
  output logic [63:0]         proc2Dmem_data,
  output MEM_SIZE             proc2Dmem_size,
  input  logic [TAG_BITS-1:0] Dmem2proc_response,
  input  logic [63:0]         Dmem2proc_data,
  input  logic [TAG_BITS-1:0] Dmem2proc_tag
);

  ARB_STATE            state_q, state_d;
  ARB_PORT             prio_q, prio_d;
  ARB_PORT             hold_port_q, hold_port_d;
  FU_MEM_PACKET        hold_pkt_q, hold_pkt_d;
  logic [TAG_BITS-1:0] tag_q, tag_d;
  logic [XLEN-1:0]     cap_q, cap_d;

  ARB_PORT             winner;
  logic [63:0]         st_lane;
  logic [XLEN-1:0]     ld_aligned;

  mem_lane_align u_align (
    .addr_off   (hold_pkt_q.addr[2:0]),
    .st_size    (hold_pkt_q.size),
    .st_data    (hold_pkt_q.data),
    .rd_data    (Dmem2proc_data),
    .st_lane    (st_lane),
    .ld_aligned (ld_aligned)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      prio_q      <= PORT_LD;
      hold_port_q <= PORT_LD;
      hold_pkt_q  <= '0;
      tag_q       <= '0;
      cap_q       <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      hold_port_q <= hold_port_d;
      hold_pkt_q  <= hold_pkt_d;
      tag_q       <= tag_d;
      cap_q       <= cap_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    prio_d            = prio_q;
    hold_port_d       = hold_port_q;
    hold_pkt_d        = hold_pkt_q;
    tag_d             = tag_q;
    cap_d             = cap_q;
    winner            = PORT_LD;
    ld_ack            = 1'b0;
    st_ack            = 1'b0;
    ld_data           = '0;
    proc2Dmem_command = BUS_NONE;
    proc2Dmem_addr    = '0;
    proc2Dmem_data    = '0;
    proc2Dmem_size    = BYTE;

    case (state_q)
      IDLE: begin
        if (!squash && (ld_req || st_req)) begin
          winner      = (ld_req && (!st_req || prio_q == PORT_LD)) ? PORT_LD : PORT_ST;
          hold_port_d = winner;
          hold_pkt_d  = (winner == PORT_LD) ? ld_mem_packet : st_mem_packet;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        proc2Dmem_command = hold_pkt_q.command;
        proc2Dmem_addr    = hold_pkt_q.addr;
        proc2Dmem_size    = hold_pkt_q.size;
        proc2Dmem_data    = (hold_port_q == PORT_ST) ? st_lane : '0;
        if (squash && hold_port_q == PORT_LD) begin
          tag_d   = '0;
          state_d = IDLE;
        end else if (Dmem2proc_response != '0) begin
          if (hold_port_q == PORT_ST) begin
            state_d = ACK;
          end else begin
            tag_d   = Dmem2proc_response;
            state_d = WAIT_LD;
          end
        end
      end
      WAIT_LD: begin
        if (squash) begin
          tag_d   = '0;
          state_d = IDLE;
        end else if (tag_q != '0 && Dmem2proc_tag == tag_q) begin
          cap_d   = ld_aligned;
          state_d = ACK;
        end
      end
      ACK: begin
        tag_d   = '0;
        state_d = IDLE;
        // A squashed load is dropped silently and does not count as a turn.
        if (hold_port_q == PORT_LD) begin
          if (!squash) begin
            ld_ack  = 1'b1;
            ld_data = cap_q;
            prio_d  = PORT_ST;
          end
        end else begin
          st_ack = 1'b1;
          prio_d = PORT_LD;
        end
      end
      default: state_d = IDLE;
    endcase

    if (reset) begin
      ld_ack            = 1'b0;
      st_ack            = 1'b0;
      ld_data           = '0;
      proc2Dmem_command = BUS_NONE;
      proc2Dmem_addr    = '0;
      proc2Dmem_data    = '0;
      proc2Dmem_size    = BYTE;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter TAG_BITS, default 4, width of the memory transaction tag.
REQ-002 clock  in  1  system clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ld_req  in  1  load FU memory request; held high until ld_ack.
REQ-005 ld_mem_packet  in  FU_MEM_PACKET  load command, addr, size; data ignored.
REQ-006 ld_ack  out  1  one-cycle load-complete pulse.
REQ-007 ld_data  out  XLEN  lane-aligned load data, low-justified, unextended; valid only while ld_ack.
REQ-008 st_req  in  1  store FU memory request; held high until st_ack.
REQ-009 st_mem_packet  in  FU_MEM_PACKET  store command, addr, data, size.
REQ-010 st_ack  out  1  one-cycle pulse: store accepted by memory.
REQ-011 squash  in  1  pipeline flush; cancels any load in flight.
REQ-012 proc2Dmem_command  out  BUS_COMMAND  BUS_NONE/BUS_LOAD/BUS_STORE.
REQ-013 proc2Dmem_addr  out  XLEN  byte address.
REQ-014 proc2Dmem_data  out  64  store data placed in its byte lane.
REQ-015 proc2Dmem_size  out  MEM_SIZE  access size.
REQ-016 Dmem2proc_response  in  TAG_BITS  nonzero = request accepted, value is its tag.
REQ-017 Dmem2proc_data  in  64  returned doubleword.
REQ-018 Dmem2proc_tag  in  TAG_BITS  nonzero = Dmem2proc_data belongs to this tag.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT_LD, ACK; one transaction outstanding at a time.
REQ-020 IDLE: bus BUS_NONE; if any req, latch winner's packet and port id into hold register, go ISSUE.
REQ-021 Arbitration round-robin: one priority bit, initially load; both requesting -> priority port wins; priority flips to the other port on every ACK.
REQ-022 ISSUE: bus driven from hold register; response == 0 -> stay ISSUE and re-drive next cycle; nonzero -> store goes ACK, load latches tag and goes WAIT_LD.
REQ-023 WAIT_LD: bus BUS_NONE; Dmem2proc_tag == latched tag and nonzero -> capture aligned data, go ACK; other tags ignored.
REQ-024 ACK: exactly one cycle; pulse ld_ack or st_ack for latched port only; ld_data driven from capture register; then IDLE.
REQ-025 Load alignment: ld_data = Dmem2proc_data >> (8*addr[2:0]), truncated to XLEN, upper bits beyond size left as returned.
REQ-026 Store alignment: proc2Dmem_data = store data << (8*addr[2:0]); other lanes zero.
REQ-027 Minimum load latency: req in IDLE at cycle 0, accept at cycle 1, tag at cycle N >= 2, ld_ack at cycle N+1.
REQ-028 Minimum store latency: req cycle 0, accept cycle 1, st_ack cycle 2.
REQ-029 squash with load in ISSUE, WAIT_LD or ACK: next state IDLE, no ld_ack, latched tag cleared so late tag return is ignored.
REQ-030 squash with store in flight: no effect; store completes normally.
REQ-031 squash in IDLE: no request latched that cycle.
REQ-032 ld_ack and st_ack never asserted together.

Reset
REQ-033 Reset: state IDLE, priority load, hold/tag/capture registers zero.
REQ-034 During reset: BUS_NONE, addr/data/size zero, ld_ack/st_ack zero, ld_data zero.
REQ-035 Reset mid-transaction abandons it; later Dmem2proc_tag returns produce no ack.

Structure
REQ-036 ARB_STATE enum and ARB_PORT enum (PORT_LD, PORT_ST) in shared sys_defs package with BUS_COMMAND, MEM_SIZE, FU_MEM_PACKET.
REQ-037 One sub-module: mem_lane_align, combinational, both shift directions from addr[2:0].

Verification
REQ-038 Load addr 0x104 size WORD, response 3 at accept, tag 3 after 4 cycles with data 0xDEADBEEF_01234567 -> one ld_ack, ld_data 0xDEADBEEF.
REQ-039 ld_req and st_req together from reset -> load served first, st_ack follows; repeat both -> store served first.
REQ-040 Store addr 0x203 size BYTE data 0xAB, response 0 for 2 cycles then 5 -> request held stable 3 cycles, proc2Dmem_data 0xAB<<24, st_ack 1 cycle later.
REQ-041 Load accepted tag 7, squash in WAIT_LD, tag 7 returns -> no ld_ack; next ld_req served normally.
REQ-042 Tag 2 returns while waiting on tag 6 -> ignored; tag 6 -> ld_ack.
REQ-043 Reset asserted in WAIT_LD -> outputs zeroed next cycle; stale tag return -> no ack.
